phase_countdown_timer: RTL

- Timer side of the signal-controller handshake; the controller sees it only through this interface.
- Two independent down-counters: the 3 s yellow-phase channel and the 27 s green-phase channel.
- Each channel loads on its LDn, counts on its C, and returns a done level (T3, T27).
- Also produces a 1 Hz-derived count and a BCD display value for the active channel.

---
 rtl/phase_countdown_timer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/phase_countdown_timer.sv
// Purpose: 3 s / 27 s countdown channels with per-second prescalers, a TICK pulse and a BCD display.
// Latency: counters update on the COUNT edge; TICK is registered (one cycle); DISP_* lag the source by one CLK.
// Backpressure: none. Each channel counts only while its C is high; LOAD wins over COUNT, otherwise it holds.
//
// Ports:
//   CLK, RSTn           clock; asynchronous active-low reset
//   C3, LD3n, SD3       3 s channel count enable, load (active-low), preset
//   C27, LD27n, SD27    27 s channel count enable, load (active-low), preset
//   T3, T27             done levels (registered)
//   CNT3, CNT27         remaining seconds per channel
//   TICK                one-cycle pulse after either channel's prescaler wraps
//   DISP_TENS/ONES      BCD of CNT3 when C3=1, otherwise of CNT27
module phase_countdown_timer #(
   parameter int TICK_DIV = 50_000_000,
   parameter int PS_W     = 26
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       C3,
   input  logic       LD3n,
   input  logic [5:0] SD3,
   input  logic       C27,
   input  logic       LD27n,
   input  logic [5:0] SD27,
   output logic       T3,
   output logic       T27,
   output logic [5:0] CNT3,
   output logic [5:0] CNT27,
   output logic       TICK,
   output logic [3:0] DISP_TENS,
   output logic [3:0] DISP_ONES
);

   localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

   logic [5:0]      r_cnt3,  r_cnt27;
   logic [PS_W-1:0] r_ps3,   r_ps27;
   logic            r_done3, r_done27;
   logic            r_tick;
   logic [3:0]      r_disp_tens, r_disp_ones;

   logic [5:0]      w_cnt3_nxt,  w_cnt27_nxt;
   logic [PS_W-1:0] w_ps3_nxt,   w_ps27_nxt;
   logic            w_done3_nxt, w_done27_nxt;
   logic            w_tick3,     w_tick27;
   logic [5:0]      w_disp_src;
   logic [5:0]      w_disp_base;
   logic [3:0]      w_disp_tens;
   logic [5:0]      w_disp_ones;

   // A channel tick happens only in COUNT mode with the prescaler at its last phase.
   assign w_tick3  = LD3n  & C3  & (r_ps3  == PS_LAST);
   assign w_tick27 = LD27n & C27 & (r_ps27 == PS_LAST);

   // 3 s channel next state
   always_comb begin
      w_cnt3_nxt  = r_cnt3;
      w_ps3_nxt   = r_ps3;
      w_done3_nxt = r_done3;
      if (!LD3n) begin
         w_cnt3_nxt  = SD3;
         w_ps3_nxt   = '0;
         w_done3_nxt = 1'b0;
      end else if (C3) begin
         if (r_ps3 == PS_LAST) begin
            w_ps3_nxt = '0;
            if (r_cnt3 != 6'd0) w_cnt3_nxt = r_cnt3 - 6'd1;
            // cnt reaching 0 on this tick, or already sitting at 0
            if (r_cnt3 <= 6'd1) w_done3_nxt = 1'b1;
         end else begin
            w_ps3_nxt = r_ps3 + 1'b1;
            if (r_cnt3 == 6'd0) w_done3_nxt = 1'b1;
         end
      end
   end

   // 27 s channel next state
   always_comb begin
      w_cnt27_nxt  = r_cnt27;
      w_ps27_nxt   = r_ps27;
      w_done27_nxt = r_done27;
      if (!LD27n) begin
         w_cnt27_nxt  = SD27;
         w_ps27_nxt   = '0;
         w_done27_nxt = 1'b0;
      end else if (C27) begin
         if (r_ps27 == PS_LAST) begin
            w_ps27_nxt = '0;
            if (r_cnt27 != 6'd0) w_cnt27_nxt = r_cnt27 - 6'd1;
            if (r_cnt27 <= 6'd1) w_done27_nxt = 1'b1;
         end else begin
            w_ps27_nxt = r_ps27 + 1'b1;
            if (r_cnt27 == 6'd0) w_done27_nxt = 1'b1;
         end
      end
   end

   // Binary (0..63) to BCD: tens picked by range, ones is the remainder.
   assign w_disp_src = C3 ? r_cnt3 : r_cnt27;

   always_comb begin
      w_disp_tens = 4'd0;
      w_disp_base = 6'd0;
      if      (w_disp_src >= 6'd60) begin w_disp_tens = 4'd6; w_disp_base = 6'd60; end
      else if (w_disp_src >= 6'd50) begin w_disp_tens = 4'd5; w_disp_base = 6'd50; end
      else if (w_disp_src >= 6'd40) begin w_disp_tens = 4'd4; w_disp_base = 6'd40; end
      else if (w_disp_src >= 6'd30) begin w_disp_tens = 4'd3; w_disp_base = 6'd30; end
      else if (w_disp_src >= 6'd20) begin w_disp_tens = 4'd2; w_disp_base = 6'd20; end
      else if (w_disp_src >= 6'd10) begin w_disp_tens = 4'd1; w_disp_base = 6'd10; end
   end

   assign w_disp_ones = w_disp_src - w_disp_base;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_cnt3      <= '0;
         r_ps3       <= '0;
         r_done3     <= 1'b0;
         r_cnt27     <= '0;
         r_ps27      <= '0;
         r_done27    <= 1'b0;
         r_tick      <= 1'b0;
         r_disp_tens <= '0;
         r_disp_ones <= '0;
      end else begin
         r_cnt3      <= w_cnt3_nxt;
         r_ps3       <= w_ps3_nxt;
         r_done3     <= w_done3_nxt;
         r_cnt27     <= w_cnt27_nxt;
         r_ps27      <= w_ps27_nxt;
         r_done27    <= w_done27_nxt;
         r_tick      <= w_tick3 | w_tick27;
         r_disp_tens <= w_disp_tens;
         r_disp_ones <= w_disp_ones[3:0];
      end
   end

   assign T3        = r_done3;
   assign T27       = r_done27;
   assign CNT3      = r_cnt3;
   assign CNT27     = r_cnt27;
   assign TICK      = r_tick;
   assign DISP_TENS = r_disp_tens;
   assign DISP_ONES = r_disp_ones;

endmodule
